// File: rtl/seg_mux_decoder.sv
// Receiver for the two-phase multiplexed 7-segment display bus: synchronizes, filters and decodes back to a 16-bit word.
// Optional SEGDEC_CHANGE_ONLY_EN: data_valid pulses only when a committed word differs from data_out (first commit always pulses).
module seg_mux_decoder #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  seg_en,
  input  logic [6:0]  seg_ab,
  input  logic [6:0]  seg_cd,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        decode_err,
  output logic        frame_err,
  output logic        signal_lost
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    WAIT_LO = 2'd1,
    WAIT_HI = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] sync1, sync2, sample_q;
  logic [7:0]  stab_cnt;
  logic        accept;
  logic [TW-1:0] to_cnt;
  logic [3:0]  dig_a, dig_c;
  logic [1:0]  ph_en;
  logic [4:0]  dec_ab, dec_cd;
  logic [15:0] new_word;
`ifdef SEGDEC_CHANGE_ONLY_EN
  logic        committed;
`endif

  // Returns {legal, digit}; segment order {g,f,e,d,c,b,a}
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    case (seg)
      7'h3F: decode_glyph = {1'b1, 4'h0};
      7'h06: decode_glyph = {1'b1, 4'h1};
      7'h5B: decode_glyph = {1'b1, 4'h2};
      7'h4F: decode_glyph = {1'b1, 4'h3};
      7'h66: decode_glyph = {1'b1, 4'h4};
      7'h6D: decode_glyph = {1'b1, 4'h5};
      7'h7D: decode_glyph = {1'b1, 4'h6};
      7'h07: decode_glyph = {1'b1, 4'h7};
      7'h7F: decode_glyph = {1'b1, 4'h8};
      7'h6F: decode_glyph = {1'b1, 4'h9};
      7'h77: decode_glyph = {1'b1, 4'hA};
      7'h7C: decode_glyph = {1'b1, 4'hB};
      7'h39: decode_glyph = {1'b1, 4'hC};
      7'h5E: decode_glyph = {1'b1, 4'hD};
      7'h79: decode_glyph = {1'b1, 4'hE};
      7'h71: decode_glyph = {1'b1, 4'hF};
      default: decode_glyph = 5'b0_0000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= '0;
      sync2    <= '0;
      sample_q <= '0;
      stab_cnt <= '0;
    end else begin
      sync1    <= {seg_en, seg_ab, seg_cd};
      sync2    <= sync1;
      sample_q <= sync2;
      // Saturating one past the accept value keeps accept a single pulse per stable sample
      if (sync2 != sample_q)
        stab_cnt <= '0;
      else if (stab_cnt != 8'(STABLE_CYCLES))
        stab_cnt <= stab_cnt + 8'd1;
    end
  end

  always_comb begin
    accept   = (stab_cnt == 8'(STABLE_CYCLES - 1));
    ph_en    = sample_q[15:14];
    dec_ab   = decode_glyph(sample_q[13:7]);
    dec_cd   = decode_glyph(sample_q[6:0]);
    new_word = {dig_a, dec_ab[3:0], dig_c, dec_cd[3:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SEEK;
      dig_a      <= '0;
      dig_c      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      decode_err <= 1'b0;
      frame_err  <= 1'b0;
`ifdef SEGDEC_CHANGE_ONLY_EN
      committed  <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      decode_err <= 1'b0;
      frame_err  <= 1'b0;
      if (accept) begin
        if (ph_en == 2'b01 || ph_en == 2'b10) begin
          frame_err <= 1'b1;
          state     <= SEEK;
        end else if (!(dec_ab[4] && dec_cd[4])) begin
          decode_err <= 1'b1;
          state      <= SEEK;
        end else if (ph_en == 2'b11) begin
          dig_a <= dec_ab[3:0];
          dig_c <= dec_cd[3:0];
          state <= WAIT_LO;
        end else if (state == WAIT_LO) begin
          data_out <= new_word;
          state    <= WAIT_HI;
`ifdef SEGDEC_CHANGE_ONLY_EN
          data_valid <= !committed || (new_word != data_out);
          committed  <= 1'b1;
`else
          data_valid <= 1'b1;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      to_cnt <= '0;
    else if (accept)
      to_cnt <= '0;
    else if (to_cnt != TW'(TIMEOUT_CYCLES))
      to_cnt <= to_cnt + 1'b1;
  end

  assign signal_lost = (to_cnt == TW'(TIMEOUT_CYCLES));

endmodule

// File: tb/tb_seg_mux_decoder.sv
// Directed-vector bench for seg_mux_decoder (STABLE_CYCLES=4, TIMEOUT_CYCLES=50).
module tb_seg_mux_decoder;

  logic        clk;
  logic        rst;
  logic [1:0]  seg_en;
  logic [6:0]  seg_ab;
  logic [6:0]  seg_cd;
  logic [15:0] data_out;
  logic        data_valid;
  logic        decode_err;
  logic        frame_err;
  logic        signal_lost;

  int pass_cnt = 0;
  int total_cnt = 0;
  int dv_n, de_n, fe_n, dv_at;

`ifdef SEGDEC_CHANGE_ONLY_EN
  localparam int REP_DV = 0;
`else
  localparam int REP_DV = 1;
`endif

  seg_mux_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(50)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_en     (seg_en),
    .seg_ab     (seg_ab),
    .seg_cd     (seg_cd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .decode_err (decode_err),
    .frame_err  (frame_err),
    .signal_lost(signal_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Holds one input pattern for n cycles, counting output pulses sampled 1 time unit after each edge
  task automatic phase(input logic [1:0] en, input logic [6:0] ab, input logic [6:0] cd, input int n);
    seg_en = en; seg_ab = ab; seg_cd = cd;
    dv_n = 0; de_n = 0; fe_n = 0; dv_at = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (data_valid) begin
        dv_n++;
        if (dv_at == 0) dv_at = i;
      end
      if (decode_err) de_n++;
      if (frame_err) fe_n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    seg_en = 2'b11; seg_ab = 7'h06; seg_cd = 7'h4F;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (data_out !== 16'h0000) $display("FAIL reset_data_out: got %h want 0000", data_out); else pass_cnt++;
    total_cnt++; if (data_valid !== 1'b0) $display("FAIL reset_data_valid: got %b want 0", data_valid); else pass_cnt++;
    total_cnt++; if (decode_err !== 1'b0) $display("FAIL reset_decode_err: got %b want 0", decode_err); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else pass_cnt++;
    total_cnt++; if (signal_lost !== 1'b0) $display("FAIL reset_signal_lost: got %b want 0", signal_lost); else pass_cnt++;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    phase(2'b11, 7'h06, 7'h4F, 20);
    phase(2'b00, 7'h5B, 7'h66, 20);
    total_cnt++; if (dv_n !== 1) $display("FAIL basic_dv_count: got %0d want 1", dv_n); else pass_cnt++;
    total_cnt++; if (dv_at !== 7) $display("FAIL basic_latency: got %0d want 7", dv_at); else pass_cnt++;
    total_cnt++; if (data_out !== 16'h1234) $display("FAIL basic_data: got %h want 1234", data_out); else pass_cnt++;
    total_cnt++; if (de_n !== 0) $display("FAIL basic_decode_err: got %0d want 0", de_n); else pass_cnt++;
    phase(2'b11, 7'h06, 7'h4F, 20);
    phase(2'b00, 7'h5B, 7'h66, 20);
    total_cnt++; if (dv_n !== REP_DV) $display("FAIL basic_repeat_dv: got %0d want %0d", dv_n, REP_DV); else pass_cnt++;
    total_cnt++; if (data_out !== 16'h1234) $display("FAIL basic_repeat_data: got %h want 1234", data_out); else pass_cnt++;
  endtask

  task automatic test_glitch;
    int de_tot;
    phase(2'b11, 7'h06, 7'h4F, 8);  de_tot = de_n;
    phase(2'b11, 7'h7F, 7'h4F, 2);  de_tot += de_n;
    phase(2'b11, 7'h06, 7'h4F, 20); de_tot += de_n;
    phase(2'b00, 7'h5B, 7'h66, 20); de_tot += de_n;
    total_cnt++; if (de_tot !== 0) $display("FAIL glitch_decode_err: got %0d want 0", de_tot); else pass_cnt++;
    total_cnt++; if (dv_n !== REP_DV) $display("FAIL glitch_dv_count: got %0d want %0d", dv_n, REP_DV); else pass_cnt++;
    total_cnt++; if (data_out !== 16'h1234) $display("FAIL glitch_data: got %h want 1234", data_out); else pass_cnt++;
  endtask

  task automatic test_illegal;
    phase(2'b11, 7'h06, 7'h4F, 20);
    phase(2'b00, 7'h00, 7'h66, 20);
    total_cnt++; if (de_n !== 1) $display("FAIL illegal_decode_err: got %0d want 1", de_n); else pass_cnt++;
    total_cnt++; if (dv_n !== 0) $display("FAIL illegal_dv: got %0d want 0", dv_n); else pass_cnt++;
    total_cnt++; if (data_out !== 16'h1234) $display("FAIL illegal_hold: got %h want 1234", data_out); else pass_cnt++;
    phase(2'b00, 7'h00, 7'h00, 20);
    total_cnt++; if (de_n !== 1) $display("FAIL illegal_both_single_pulse: got %0d want 1", de_n); else pass_cnt++;
    // Back in SEEK: a legal low phase alone must not commit
    phase(2'b00, 7'h5B, 7'h66, 20);
    total_cnt++; if (dv_n !== 0) $display("FAIL illegal_seek_no_commit: got %0d want 0", dv_n); else pass_cnt++;
    phase(2'b11, 7'h77, 7'h39, 20);
    phase(2'b00, 7'h7C, 7'h5E, 20);
    total_cnt++; if (dv_n !== 1) $display("FAIL illegal_recover_dv: got %0d want 1", dv_n); else pass_cnt++;
    total_cnt++; if (data_out !== 16'hABCD) $display("FAIL illegal_recover_data: got %h want abcd", data_out); else pass_cnt++;
  endtask

  task automatic test_frame;
    phase(2'b11, 7'h6D, 7'h07, 20);
    phase(2'b10, 7'h00, 7'h07, 10);
    total_cnt++; if (fe_n !== 1) $display("FAIL frame_err_count: got %0d want 1", fe_n); else pass_cnt++;
    total_cnt++; if (de_n !== 0) $display("FAIL frame_priority: got decode_err %0d want 0", de_n); else pass_cnt++;
    total_cnt++; if (dv_n !== 0) $display("FAIL frame_dv: got %0d want 0", dv_n); else pass_cnt++;
    phase(2'b00, 7'h7D, 7'h7F, 20);
    total_cnt++; if (dv_n !== 0) $display("FAIL frame_no_partial: got %0d want 0", dv_n); else pass_cnt++;
    total_cnt++; if (data_out !== 16'hABCD) $display("FAIL frame_hold: got %h want abcd", data_out); else pass_cnt++;
    phase(2'b11, 7'h6D, 7'h07, 20);
    phase(2'b00, 7'h7D, 7'h7F, 20);
    total_cnt++; if (dv_n !== 1) $display("FAIL frame_recover_dv: got %0d want 1", dv_n); else pass_cnt++;
    total_cnt++; if (dv_at !== 7) $display("FAIL frame_recover_latency: got %0d want 7", dv_at); else pass_cnt++;
    total_cnt++; if (data_out !== 16'h5678) $display("FAIL frame_recover_data: got %h want 5678", data_out); else pass_cnt++;
  endtask

  task automatic test_signal_lost;
    int k;
    // Last accept cleared the counter at edge 7 of the previous phase; 43 counts by now
    repeat (30) @(posedge clk);
    #1;
    total_cnt++; if (signal_lost !== 1'b0) $display("FAIL lost_early: got %b want 0", signal_lost); else pass_cnt++;
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (signal_lost && k == 0) k = i;
    end
    total_cnt++; if (k !== 7) $display("FAIL lost_rise_cycle: got %0d want 7", k); else pass_cnt++;
    total_cnt++; if (data_out !== 16'h5678) $display("FAIL lost_data_hold: got %h want 5678", data_out); else pass_cnt++;
    seg_en = 2'b11; seg_ab = 7'h6D; seg_cd = 7'h07;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (!signal_lost && k == 0) k = i;
    end
    total_cnt++; if (k !== 7) $display("FAIL lost_fall_cycle: got %0d want 7", k); else pass_cnt++;
    phase(2'b00, 7'h7D, 7'h7F, 20);
    total_cnt++; if (dv_n !== REP_DV) $display("FAIL lost_resume_dv: got %0d want %0d", dv_n, REP_DV); else pass_cnt++;
    total_cnt++; if (signal_lost !== 1'b0) $display("FAIL lost_resume_level: got %b want 0", signal_lost); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    phase(2'b11, 7'h6D, 7'h07, 20);
    seg_en = 2'b00; seg_ab = 7'h7D; seg_cd = 7'h7F;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (data_out !== 16'h0000) $display("FAIL mid_reset_data: got %h want 0000", data_out); else pass_cnt++;
    total_cnt++; if ({data_valid, decode_err, frame_err, signal_lost} !== 4'b0000)
      $display("FAIL mid_reset_flags: got %b want 0000", {data_valid, decode_err, frame_err, signal_lost}); else pass_cnt++;
    rst = 1'b1;
    phase(2'b00, 7'h7D, 7'h7F, 20);
    total_cnt++; if (dv_n !== 0) $display("FAIL mid_low_only: got %0d want 0", dv_n); else pass_cnt++;
    total_cnt++; if (de_n !== 0) $display("FAIL mid_decode_err: got %0d want 0", de_n); else pass_cnt++;
    phase(2'b11, 7'h6D, 7'h07, 20);
    phase(2'b00, 7'h7D, 7'h7F, 20);
    total_cnt++; if (dv_n !== 1) $display("FAIL mid_first_commit: got %0d want 1", dv_n); else pass_cnt++;
    total_cnt++; if (data_out !== 16'h5678) $display("FAIL mid_data: got %h want 5678", data_out); else pass_cnt++;
    phase(2'b11, 7'h6D, 7'h07, 20);
    phase(2'b00, 7'h7D, 7'h7F, 20);
    total_cnt++; if (dv_n !== REP_DV) $display("FAIL mid_repeat_dv: got %0d want %0d", dv_n, REP_DV); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_glitch;
    test_illegal;
    test_frame;
    test_signal_lost;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
